power_sequencer: RTL and testbench

- Multi-cycle unsigned power unit: computes base^exp (8-bit result) by repeated shift-and-add multiplication.
- Owns no adder. It drives the team's 8-bit adder_subtractor operands and op, and consumes its combinational sum in the same cycle. It therefore sits directly upstream and downstream of the adder.
- Reports a sticky unsigned overflow flag and a one-cycle done pulse.

---
 rtl/power_sequencer.sv | 171 +++++++++++++++++
 tb/tb_power_sequencer.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : power_sequencer
// Purpose  : Multi-cycle unsigned power unit. Computes base^exp (8-bit result)
//            by repeated shift-and-add multiplication, one multiplier bit per
//            cycle. The unit has no adder of its own: it drives an external
//            8-bit adder (add_a/add_b/add_op) and consumes its combinational
//            sum (add_s) in the same cycle.
// Ports    : clk, rst_n          - clock, asynchronous active-low reset
//            start, base, exp    - request and operands (sampled in IDLE)
//            add_a, add_b, add_op- adder drive (zero outside MUL, op = add)
//            add_s               - adder sum, same cycle
//            busy, done          - MUL-state flag, one-cycle completion pulse
//            result, overflow    - final value and sticky overflow, held
//                                  until the next accepted start
// Revision : 1.0 - initial release
// ============================================================================
module power_sequencer #(
    parameter int EXP_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [7:0]       base,
    input  logic [EXP_W-1:0] exp,
    output logic [7:0]       add_a,
    output logic [7:0]       add_b,
    output logic             add_op,
    input  logic [7:0]       add_s,
    output logic             busy,
    output logic             done,
    output logic [7:0]       result,
    output logic             overflow
);

    localparam logic [1:0]       c_ST_IDLE = 2'd0;
    localparam logic [1:0]       c_ST_MUL  = 2'd1;
    localparam logic [1:0]       c_ST_DONE = 2'd2;
    localparam logic [EXP_W-1:0] c_REM_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
    localparam logic [EXP_W-1:0] c_EXP_ZERO = '0;

    logic [1:0]       state_q, state_d;
    logic [7:0]       b_q;        // multiplier: bits walked LSB first
    logic [7:0]       cur_q;      // current power (mod 256)
    logic [7:0]       acc_q;      // partial product of cur_q * b_q
    logic [2:0]       k_q;        // bit-step index within one multiply
    logic [EXP_W-1:0] rem_q;      // multiplies still to perform
    logic             ovf_q;      // sticky overflow for the running operation
    logic [7:0]       result_q;
    logic             ovf_out_q;

    // Full-width shift so bits pushed past bit 7 can be detected as truncation.
    logic [15:0] w_shift;
    logic        w_bit;
    logic [7:0]  w_term;
    logic        w_step_ovf;
    logic        w_ovf_next;
    logic        w_last_step;
    logic        w_last_mul;

    always_comb begin
        w_shift     = {8'h00, cur_q} << k_q;
        w_bit       = b_q[k_q];
        w_term      = w_bit ? w_shift[7:0] : 8'h00;
        // An added term overflows if shifted bits were lost or the sum wrapped.
        w_step_ovf  = w_bit && ((w_shift[15:8] != 8'h00) || (add_s < add_a));
        w_ovf_next  = ovf_q | w_step_ovf;
        w_last_step = (k_q == 3'd7);
        w_last_mul  = w_last_step && (rem_q == c_REM_ONE);
    end

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= c_ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            c_ST_IDLE: begin
                if (start) begin
                    state_d = (exp == c_EXP_ZERO) ? c_ST_DONE : c_ST_MUL;
                end
            end
            c_ST_MUL: begin
                if (w_last_mul) begin
                    state_d = c_ST_DONE;
                end
            end
            c_ST_DONE: state_d = c_ST_IDLE;
            default:   state_d = c_ST_IDLE;
        endcase
    end

    // ---------------- output logic ----------------
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        add_a  = 8'h00;
        add_b  = 8'h00;
        add_op = 1'b0;
        case (state_q)
            c_ST_MUL: begin
                busy  = 1'b1;
                add_a = acc_q;
                add_b = w_term;
            end
            c_ST_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign result   = result_q;
    assign overflow = ovf_out_q;

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b_q       <= 8'h00;
            cur_q     <= 8'h00;
            acc_q     <= 8'h00;
            k_q       <= 3'd0;
            rem_q     <= '0;
            ovf_q     <= 1'b0;
            result_q  <= 8'h00;
            ovf_out_q <= 1'b0;
        end else begin
            case (state_q)
                c_ST_IDLE: begin
                    if (start) begin
                        b_q   <= base;
                        cur_q <= 8'h01;
                        acc_q <= 8'h00;
                        k_q   <= 3'd0;
                        rem_q <= exp;
                        ovf_q <= 1'b0;
                        if (exp == c_EXP_ZERO) begin
                            result_q  <= 8'h01;
                            ovf_out_q <= 1'b0;
                        end
                    end
                end
                c_ST_MUL: begin
                    ovf_q <= w_ovf_next;
                    if (w_last_step) begin
                        // Final bit of this multiply: the sum is the new power.
                        cur_q <= add_s;
                        acc_q <= 8'h00;
                        k_q   <= 3'd0;
                        rem_q <= rem_q - c_REM_ONE;
                        if (rem_q == c_REM_ONE) begin
                            result_q  <= add_s;
                            ovf_out_q <= w_ovf_next;
                        end
                    end else begin
                        acc_q <= add_s;
                        k_q   <= k_q + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_power_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_power_sequencer
// Purpose  : Self-checking bench for power_sequencer. Models the external
//            adder, runs directed and random operations, and compares against
//            an arithmetic model of base^exp with exact overflow.
// Revision : 1.0 - initial release
// ============================================================================
module tb_power_sequencer;

    localparam int EXP_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [7:0]       base_s;
    logic [EXP_W-1:0] exp_s;
    logic [7:0]       add_a;
    logic [7:0]       add_b;
    logic             add_op;
    logic [7:0]       add_s;
    logic             busy;
    logic             done;
    logic [7:0]       result;
    logic             overflow;

    int n_cmp;
    int n_err;

    // Expected held values of result/overflow between operations.
    logic [7:0] prev_r;
    bit         prev_o;

    power_sequencer #(.EXP_W(EXP_W)) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .base     (base_s),
        .exp      (exp_s),
        .add_a    (add_a),
        .add_b    (add_b),
        .add_op   (add_op),
        .add_s    (add_s),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow)
    );

    // External adder: op 0 adds, op 1 subtracts.
    assign add_s = add_op ? (add_a - add_b) : (add_a + add_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned expv);
        n_cmp++;
        if (obs !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, expv, $time);
        end
    endtask

    // Reference: true power tracked with saturation for overflow, and mod 256
    // for the value. Overflow means the true power ever exceeded 255.
    task automatic model(input logic [7:0] b, input logic [EXP_W-1:0] e,
                         output logic [7:0] r, output bit o);
        int unsigned modv;
        int unsigned sat;
        modv = 1;
        sat  = 1;
        o    = 1'b0;
        for (int i = 0; i < int'(e); i++) begin
            modv = (modv * b) % 256;
            sat  = sat * b;
            if (sat > 255) begin
                o   = 1'b1;
                sat = 256;
            end
        end
        r = modv[7:0];
    endtask

    // Run one operation; mid_n >= 0 pulses an extra start (base 7) at that
    // cycle offset, which must be ignored.
    task automatic run_op(input logic [7:0] b, input logic [EXP_W-1:0] e, input int mid_n);
        logic [7:0] er;
        bit         eo;
        int         n;
        int         busy_cnt;
        int         nmul;
        bit         seen;
        model(b, e, er, eo);
        nmul = 8 * int'(e);
        @(negedge clk);
        start  = 1'b1;
        base_s = b;
        exp_s  = e;
        @(negedge clk);               // edge E0 has passed; n = edges since E0
        start  = 1'b0;
        base_s = 8'($urandom);        // operands must have been captured
        exp_s  = EXP_W'($urandom);
        n = 0;
        busy_cnt = 0;
        seen = 1'b0;
        while (!seen && n <= nmul + 4) begin
            chk("add_op", add_op, 0);
            chk("busy", busy, (n < nmul) ? 1 : 0);
            if (busy) begin
                busy_cnt++;
                if (!b[n % 8]) chk("add_b_zero", add_b, 0);
            end else begin
                chk("idle_add", {add_a, add_b}, 0);
            end
            if (n == 0 && e != 0) begin
                chk("held_result", result, prev_r);
                chk("held_ovf", overflow, prev_o);
            end
            if (done) begin
                seen = 1'b1;
                chk("latency", n, nmul);
                chk("busy_cycles", busy_cnt, nmul);
                chk("result", result, er);
                chk("overflow", overflow, eo);
            end else begin
                if (n == mid_n) begin
                    start  = 1'b1;
                    base_s = 8'd7;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                n++;
            end
        end
        start = 1'b0;
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("done_pulse_width", done, 0);
        chk("result_hold", result, er);
        chk("ovf_hold", overflow, eo);
        prev_r = er;
        prev_o = eo;
    endtask

    // Start base=5 exp=3, drop reset for one cycle at offset 10.
    task automatic run_reset_abort();
        @(negedge clk);
        start  = 1'b1;
        base_s = 8'd5;
        exp_s  = 3;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 10; n++) @(negedge clk);
        chk("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 30; n++) begin
            chk("no_done_after_abort", done, 0);
            chk("no_busy_after_abort", busy, 0);
            @(negedge clk);
        end
        prev_r = 8'd0;
        prev_o = 1'b0;
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        prev_r = 8'd0;
        prev_o = 1'b0;
        rst_n  = 1'b0;
        start  = 1'b0;
        base_s = 8'd0;
        exp_s  = '0;
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_result", result, 0);
        chk("reset_ovf", overflow, 0);
        chk("reset_add", {add_a, add_b}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases
        run_op(8'd3,   4, -1);    // 81
        run_op(8'd0,   0, -1);    // 1
        run_op(8'd16,  2, -1);    // truncation: 0, ovf
        run_op(8'd15,  2, -1);    // 225, ovf cleared
        run_op(8'd255, 2, -1);    // wrap: 1, ovf
        run_op(8'd2,   5, 13);    // mid-MUL start ignored: 32
        run_op(8'd2,   8, -1);    // 0, ovf
        run_op(8'd0,   15, -1);   // 0, no ovf
        run_op(8'd1,   15, -1);   // 1, no ovf
        run_op(8'd255, 0, -1);    // exp=0 gives 1
        run_reset_abort();
        run_op(8'd5,   3, -1);    // 125

        // Random operations
        for (int i = 0; i < 40; i++) begin
            logic [7:0]       rb;
            logic [EXP_W-1:0] re;
            int               mid;
            rb = 8'($urandom);
            if (i % 3 == 0) rb = 8'($urandom_range(0, 4));
            re = EXP_W'($urandom);
            mid = -1;
            if (re != 0 && ($urandom % 2) == 1)
                mid = int'($urandom_range(0, 8 * int'(re) - 1));
            run_op(rb, re, mid);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "simulation timeout");
    end

endmodule
`default_nettype wire
